// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin arbiter sharing one divider between NUM_REQ requesters (option: DIV_ARB_TIMEOUT_EN)
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_div0,
    output logic                     rsp_err,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic                     div_valid,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("div_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  grant_dividend;
    logic [WIDTH-1:0]  grant_divisor;
    logic [ID_W-1:0]   next_ptr;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic              err_q;
    logic [TO_W-1:0]   to_cnt;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Requester index (rr_ptr + step) folded back into 0..NUM_REQ-1
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Search upward from rr_ptr with wrap for the first requester asking
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[wrap_add(rr_ptr, i)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_add(rr_ptr, i);
            end
        end
    end

    assign grant_dividend = req_dividend[int'(grant_id)*WIDTH +: WIDTH];
    assign grant_divisor  = req_divisor[int'(grant_id)*WIDTH +: WIDTH];
    assign next_ptr       = (int'(cur_id) == NUM_REQ - 1) ? '0 : cur_id + 1'b1;

    // Accept pulse only while idle; forced low during reset so every output is 0 under rst
    assign req_ready = (!rst && state == S_IDLE && grant_vld)
                     ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;

    // Sequencer: grant, start the divider, wait for its one-cycle result, hold the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            cur_id        <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
            err_q         <= 1'b0;
            to_cnt        <= '0;
`endif
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        cur_id       <= grant_id;
                        rsp_id       <= grant_id;
                        div_dividend <= grant_dividend;
                        div_divisor  <= grant_divisor;
`ifdef DIV_ARB_TIMEOUT_EN
                        err_q        <= 1'b0;
`endif
                        if (grant_divisor == '0) begin
                            // Divide by zero never reaches the divider
                            rsp_quotient  <= '0;
                            rsp_remainder <= grant_dividend;
                            rsp_div0      <= 1'b1;
                            rsp_valid     <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            rsp_div0  <= 1'b0;
                            div_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef DIV_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Divider result lives for one cycle only, so capture it now
                    if (div_valid) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_valid     <= 1'b1;
                        state         <= S_RESP;
`ifdef DIV_ARB_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        err_q         <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - randomized self-checking bench for div_share_arbiter against a transaction model
module tb_div_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*W-1:0] req_dividend;
    logic [NR*W-1:0] req_divisor;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [W-1:0]  rsp_quotient;
    logic [W-1:0]  rsp_remainder;
    logic          rsp_div0;
    logic          rsp_err;
    logic          div_start;
    logic [W-1:0]  div_dividend;
    logic [W-1:0]  div_divisor;
    logic          div_valid;
    logic [W-1:0]  div_quotient;
    logic [W-1:0]  div_remainder;

    int errors = 0;
    int checks = 0;
    int model_ptr = 0;
    logic div_mute = 1'b0;

    div_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div0(rsp_div0), .rsp_err(rsp_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid(div_valid), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-step divider: result pulse 17 cycles after the start pulse, zero otherwise
    logic [W-1:0] pa, pb;
    int           pcnt;
    logic         pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_valid <= 1'b0; div_quotient <= '0; div_remainder <= '0;
            pend <= 1'b0; pcnt <= 0; pa <= '0; pb <= '0;
        end else begin
            div_valid <= 1'b0; div_quotient <= '0; div_remainder <= '0;
            if (div_start && !div_mute) begin
                pend <= 1'b1; pcnt <= 16; pa <= div_dividend; pb <= div_divisor;
            end else if (pend) begin
                if (pcnt == 1) begin
                    div_valid <= 1'b1; div_quotient <= pa / pb; div_remainder <= pa % pb;
                    pend <= 1'b0;
                end else begin
                    pcnt <= pcnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int model_grant(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) begin
            if (mask[(model_ptr + i) % NR]) return (model_ptr + i) % NR;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_q"}, rsp_quotient, 0);
        chk({tag, "_rsp_r"}, rsp_remainder, 0);
        chk({tag, "_rsp_div0"}, rsp_div0, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_div_start"}, div_start, 0);
        chk({tag, "_div_dividend"}, div_dividend, 0);
        chk({tag, "_div_divisor"}, div_divisor, 0);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        req_valid = '1;
        #1;
        check_all_zero("reset");
        step(); step();
        req_valid = '0;
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Wait (bounded) for an accept; returns cycles waited or -1 on timeout
    task automatic wait_grant(output int waited);
        waited = 0;
        #1;
        while (req_ready == '0 && waited < 30) begin
            step(); #1; waited++;
        end
        if (req_ready == '0) waited = -1;
    endtask

    task automatic run_txn(input logic [NR-1:0] mask, input logic [NR*W-1:0] dvds,
                           input logic [NR*W-1:0] dvss, input int hold);
        int g, lat, waited;
        logic [W-1:0] a, b, eq, er;
        logic ediv0;
        req_valid = mask; req_dividend = dvds; req_divisor = dvss; rsp_ready = (hold == 0);
        wait_grant(waited);
        if (waited < 0) begin
            chk("grant_timeout", 0, 1);
            req_valid = '0;
            return;
        end
        chk("grant_wait", waited, 0);
        g = model_grant(mask);
        chk("req_ready_onehot", req_ready, 32'(1) << g);
        a = dvds[g*W +: W]; b = dvss[g*W +: W];
        if (b == 0) begin eq = 0; er = a; ediv0 = 1'b1; lat = 1; end
        else begin eq = a / b; er = a % b; ediv0 = 1'b0; lat = 19; end
        for (int c = 1; c <= lat; c++) begin
            step();
            req_valid = mask & ~(NR'(1) << g);
            #1;
            if (c == 1) begin
                chk("div_start", div_start, (b != 0));
                if (b != 0) begin
                    chk("div_dividend", div_dividend, a);
                    chk("div_divisor", div_divisor, b);
                end
            end
            if (c == 2) chk("div_start_once", div_start, 0);
            if (c < lat) begin
                chk("busy_rsp_valid", rsp_valid, 0);
                chk("busy_req_ready", req_ready, 0);
            end
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, g);
        chk("rsp_quotient", rsp_quotient, eq);
        chk("rsp_remainder", rsp_remainder, er);
        chk("rsp_div0", rsp_div0, ediv0);
        chk("rsp_err", rsp_err, 0);
        if (hold > 0) begin
            for (int h = 1; h < hold; h++) begin
                step(); #1;
                chk("hold_rsp_valid", rsp_valid, 1);
                chk("hold_rsp_id", rsp_id, g);
                chk("hold_rsp_q", rsp_quotient, eq);
                chk("hold_rsp_r", rsp_remainder, er);
                chk("hold_req_ready", req_ready, 0);
            end
            step();
            rsp_ready = 1'b1;
            #1;
            chk("hs_rsp_valid", rsp_valid, 1);
        end
        step();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", rsp_valid, 0);
        model_ptr = (g + 1) % NR;
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NR*W-1:0] dv, ds;
        int waited, g;
        logic any_rsp;
        rst = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
        do_reset();

        // Single request, requester 0, 100/7, ready held high
        dv = '0; ds = '0; dv[0*W +: W] = 100; ds[0*W +: W] = 7;
        run_txn(4'b0001, dv, ds, 0);

        // All four requesting continuously from reset: grants 0,1,2,3,0
        do_reset();
        dv = {16'd777, 16'd65535, 16'd500, 16'd1000};
        ds = {16'd10,  16'd255,   16'd9,   16'd3};
        for (int k = 0; k < 5; k++) begin
            chk("rr_order_ptr", model_grant(4'b1111), k % NR);
            run_txn(4'b1111, dv, ds, k % 2);
        end

        // Divide by zero on requester 2
        dv = '0; ds = '0; dv[2*W +: W] = 1234;
        run_txn(4'b0100, dv, ds, 1);

        // Response backpressure for 10 cycles with other requesters waiting
        dv = {16'd40000, 16'd12, 16'd999, 16'd31};
        ds = {16'd3, 16'd5, 16'd0, 16'd4};
        run_txn(4'b1111, dv, ds, 10);

        // Reset during WAIT drops the transaction
        dv = '0; ds = '0; dv[1*W +: W] = 50; ds[1*W +: W] = 7;
        req_valid = 4'b0010; req_dividend = dv; req_divisor = ds;
        wait_grant(waited);
        chk("midrst_grant", (waited >= 0), 1);
        step(); req_valid = '0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        step(); step();
        rst = 1'b0; model_ptr = 0;
        any_rsp = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(); #1;
            if (rsp_valid || div_start) any_rsp = 1'b1;
        end
        chk("midrst_no_rsp", any_rsp, 0);
        dv = '0; ds = '0; dv[1*W +: W] = 50; ds[1*W +: W] = 5; dv[3*W +: W] = 9; ds[3*W +: W] = 2;
        run_txn(4'b1010, dv, ds, 0);

        // Divider never answers
        step();
        div_mute = 1'b1;
        dv = '0; ds = '0; dv[0*W +: W] = 300; ds[0*W +: W] = 3;
        req_valid = 4'b0001; req_dividend = dv; req_divisor = ds;
        wait_grant(waited);
        chk("mute_grant", (waited >= 0), 1);
        g = model_grant(4'b0001);
`ifdef DIV_ARB_TIMEOUT_EN
        for (int c = 1; c <= 22; c++) begin
            step(); req_valid = '0; #1;
            if (c < 22) chk("to_busy_rsp_valid", rsp_valid, 0);
        end
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_q", rsp_quotient, 0);
        chk("to_rsp_r", rsp_remainder, 0);
        chk("to_rsp_id", rsp_id, g);
        step(); rsp_ready = 1'b1; #1;
        step(); rsp_ready = 1'b0; #1;
        chk("to_rsp_drop", rsp_valid, 0);
        model_ptr = (g + 1) % NR;
        div_mute = 1'b0;
`else
        any_rsp = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            step(); req_valid = '0; #1;
            if (rsp_valid || rsp_err) any_rsp = 1'b1;
        end
        chk("mute_stays_wait", any_rsp, 0);
        chk("mute_id_latched", rsp_id, g);
        div_mute = 1'b0;
        do_reset();
`endif

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            logic [NR-1:0] m;
            m = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                dv[i*W +: W] = W'($urandom);
                if ($urandom_range(0, 7) == 0) ds[i*W +: W] = 0;
                else if ($urandom_range(0, 1) == 0) ds[i*W +: W] = W'($urandom_range(1, 20));
                else ds[i*W +: W] = W'($urandom_range(1, 65535));
            end
            run_txn(m, dv, ds, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Round-robin arbiter and sequencer that shares one 16-bit restoring divider between `NUM_REQ` requesters. It accepts one request at a time, latches its operands, and drives the divider's start/operand inputs. It captures the quotient and remainder in the single cycle the divider flags valid, then returns them with the requester's index under a valid/ready response handshake. It sits between the client blocks (display/control logic) and the single divider instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 16: operand width; must match the divider.
- `TIMEOUT`, default 64: watchdog limit in cycles; used only with `DIV_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `req_dividend` in NUM_REQ*WIDTH: packed operands; slice i belongs to requester i.
- `req_divisor` in NUM_REQ*WIDTH: packed operands; slice i belongs to requester i.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out clog2(NUM_REQ): index of the requester that owns the result.
- `rsp_quotient` out WIDTH: result quotient.
- `rsp_remainder` out WIDTH: result remainder.
- `rsp_div0` out 1: divisor was zero.
- `rsp_err` out 1: watchdog expired; always 0 without the macro.
- `div_start` out 1: divider start, one-cycle pulse.
- `div_dividend` out WIDTH: latched operand, stable from ISSUE through WAIT.
- `div_divisor` out WIDTH: latched operand, stable from ISSUE through WAIT.
- `div_valid` in 1: divider completion pulse, one cycle.
- `div_quotient` in WIDTH: divider result; meaningful only while `div_valid`=1.
- `div_remainder` in WIDTH: divider result; meaningful only while `div_valid`=1.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid`, grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Assert `req_ready[g]` for this one cycle only.
  - Latch dividend, divisor and g.
  - If the latched divisor is 0, bypass the divider: quotient=0, remainder=dividend, `rsp_div0`=1, next state RESP.
  - Otherwise next state ISSUE.
- **ISSUE**: `div_start`=1 for exactly one cycle; next state WAIT.
- **WAIT**
  - When `div_valid`=1, capture `div_quotient` and `div_remainder` in that same cycle; next state RESP.
  - The divider clears its outputs the following cycle, so capture must happen in the `div_valid` cycle.
- **RESP**
  - Hold `rsp_*` stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_valid && rsp_ready`: set `rr_ptr` = (g+1) mod NUM_REQ; next state IDLE.
- `div_valid` is ignored in IDLE, ISSUE and RESP.
- Requesters must hold their operands until `req_ready`; the block samples operands only in the grant cycle.
- A requester that deasserts `req_valid` before grant simply loses its turn.

## Timing
- **Reset values** (asynchronous on `rst`=1): state IDLE, `rr_ptr`=0, all outputs 0. This covers `req_ready`, `rsp_valid`, `rsp_id`, `rsp_quotient`, `rsp_remainder`, `rsp_div0`, `rsp_err`, `div_start`, `div_dividend` and `div_divisor`.
- **Reset mid-operation**: the transaction is dropped and no response is produced. The divider shares `rst`.
- **Latency with the 16-step divider**:
  - Accept at cycle t, `div_start` at t+1, `div_valid` at t+18, `rsp_valid` at t+19.
  - Divide-by-zero: `rsp_valid` at t+1.
- **Throughput**: at most one request in flight; next grant no earlier than the cycle after response acceptance.
- **Simultaneous `req_valid`**: round-robin decides. The just-served requester has the lowest priority next time.
- `rsp_ready` held high: RESP lasts one cycle.

## Configuration
- Macro `DIV_ARB_TIMEOUT_EN`.
- **Defined**:
  - A counter runs in WAIT, cleared on ISSUE.
  - If it reaches `TIMEOUT` without `div_valid`, go to RESP with `rsp_err`=1, quotient=0 and remainder=0.
  - A late `div_valid` is ignored.
- **Undefined**: no counter; WAIT holds indefinitely; `rsp_err` is tied to 0.

## Test plan
- Single request, requester 0, 100/7, `rsp_ready`=1 → `rsp_valid` at accept+19 with `rsp_id`=0, quotient 14, remainder 2, `rsp_div0`=0.
- Requesters 0..3 all request continuously, each with distinct operands, from reset → grants in order 0,1,2,3,0. Each response carries the matching id and the correct result, e.g. id2 with 65535/255 gives 257 r0.
- Requester 2 with 1234/0 → `rsp_valid` the cycle after accept: quotient 0, remainder 1234, `rsp_div0`=1; `div_start` never pulses.
- Response backpressure: `rsp_ready`=0 for 10 cycles → `rsp_*` stable throughout; no new `req_ready` until the handshake; grant next cycle after.
- `rst` pulsed during WAIT → all outputs 0 immediately; no response. A fresh request 50/5 afterwards returns 10 r0 with id as granted from `rr_ptr`=0.
- With `DIV_ARB_TIMEOUT_EN`, `TIMEOUT`=20, divider `div_valid` suppressed → `rsp_err`=1 at ISSUE+21. Without the macro, the block stays in WAIT and `rsp_valid` stays 0.
